// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV64 decode front end: base opcodes, ALUOp
// encodings, the bubble instruction, immediate-format selection and the
// control-signal bundle produced by decode.
// -----------------------------------------------------------------------------
package rv_pkg;

    // Bubble instruction: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Supported base opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALUOp encodings seen by the EX-stage ALU controller
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Immediate layout of an instruction
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    // Control bundle handed to ID/EX
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    // Map an opcode onto its immediate layout; unknown opcodes carry none.
    function automatic imm_sel_e imm_sel_of(input logic [6:0] opcode);
        imm_sel_e sel;
        sel = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: sel = IMM_I;
            OP_STORE:                 sel = IMM_S;
            OP_BRANCH:                sel = IMM_B;
            OP_LUI:                   sel = IMM_U;
            OP_JAL:                   sel = IMM_J;
            default:                  sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/if_id_decode_stage_imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator. Picks the I/S/B/U/J layout from the
// opcode and sign-extends from instr[31] to XLEN. Formats without an
// immediate (R-type, unknown opcodes) produce zero.
//
// Ports:
//   instr  in   32    instruction word
//   imm    out  XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    // Immediate assembly; B and J offsets are halfword aligned so bit 0 is 0.
    always_comb begin
        imm = '0;
        case (imm_sel_of(instr[6:0]))
            IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
            IMM_J:   imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/if_id_decode_stage.sv
// -----------------------------------------------------------------------------
// if_id_decode_stage
// Front half of the RV64 decode stage: IF/ID pipeline register, instruction
// decode, load-use hazard detection (one-cycle stall + bubble) and EX flush.
//
// Ports:
//   clk            in   1     pipeline clock, rising edge
//   reset          in   1     asynchronous, active-low reset
//   if_valid       in   1     fetch presents a valid instruction
//   if_pc          in   XLEN  PC of fetched instruction
//   if_instr       in   ILEN  fetched instruction word
//   flush          in   1     taken branch/jump in EX, kill ID
//   fetch_stall    out  1     fetch must hold PC/instruction
//   rs1/rs2/rd     out  5     register addresses (always driven)
//   id_valid       out  1     ID holds a real instruction being issued
//   id_pc          out  XLEN  PC of instruction in ID
//   id_imm         out  XLEN  sign-extended immediate
//   id_funct3      out  3     instr[14:12]
//   id_funct7b5    out  1     instr[30]
//   RegWrite..Jump out  1     control signals, zero unless issuing
//   ALUOp          out  2     00 add, 01 branch compare, 10 funct decode
//   illegal_instr  out  1     valid instruction with unsupported opcode
//
// Optional build macro IFID_PERF_CNT_EN adds saturating 32-bit stall_count
// and flush_count outputs.
// -----------------------------------------------------------------------------
module if_id_decode_stage #(
    parameter int                XLEN      = 64,
    parameter int                ILEN      = 32,
    parameter logic [ILEN-1:0]   NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [ILEN-1:0] if_instr,
    input  logic            flush,
    output logic            fetch_stall,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_imm,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            ALUSrc,
    output logic            Branch,
    output logic            Jump,
    output logic [1:0]      ALUOp,
    output logic            illegal_instr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    import rv_pkg::*;

    // IF/ID pipeline register
    logic            valid_r;
    logic [XLEN-1:0] pc_r;
    logic [ILEN-1:0] instr_r;

    // What was issued into EX last cycle (bubbles issue rd=0, no load)
    logic [4:0]      ex_rd_r;
    logic            ex_memread_r;

    // Decode results
    ctrl_t           ctrl_s;
    ctrl_t           ctrl_out_s;
    logic            legal_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic            hazard_s;
    logic            issue_s;
    logic [6:0]      opcode_s;

    assign opcode_s = instr_r[6:0];
    assign rs1      = instr_r[19:15];
    assign rs2      = instr_r[24:20];
    assign rd       = instr_r[11:7];

    // Opcode decode: control bundle, legality and source-register usage.
    always_comb begin
        ctrl_s        = '0;
        ctrl_s.alu_op = ALUOP_ADD;
        legal_s       = 1'b0;
        uses_rs1_s    = 1'b0;
        uses_rs2_s    = 1'b0;
        case (opcode_s)
            OP_R: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_op    = ALUOP_FUNCT;
                legal_s          = 1'b1;
                uses_rs1_s       = 1'b1;
                uses_rs2_s       = 1'b1;
            end
            OP_IMM: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALUOP_FUNCT;
                legal_s          = 1'b1;
                uses_rs1_s       = 1'b1;
            end
            OP_LOAD: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_read   = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                legal_s           = 1'b1;
                uses_rs1_s        = 1'b1;
            end
            OP_STORE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                legal_s          = 1'b1;
                uses_rs1_s       = 1'b1;
                uses_rs2_s       = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_s.branch = 1'b1;
                ctrl_s.alu_op = ALUOP_BRANCH;
                legal_s       = 1'b1;
                uses_rs1_s    = 1'b1;
                uses_rs2_s    = 1'b1;
            end
            OP_LUI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                legal_s          = 1'b1;
            end
            OP_JAL: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                legal_s          = 1'b1;
            end
            OP_JALR: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                legal_s          = 1'b1;
                uses_rs1_s       = 1'b1;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // A load in EX whose destination feeds this instruction cannot forward
    // in time; x0 is never a real dependency.
    assign hazard_s = valid_r & ex_memread_r & (ex_rd_r != 5'd0) &
                      ((uses_rs1_s & (rs1 == ex_rd_r)) |
                       (uses_rs2_s & (rs2 == ex_rd_r)));

    // Flush wins over the hazard: the instruction is killed, so there is
    // nothing to stall for.
    assign issue_s     = valid_r & legal_s & ~hazard_s & ~flush;
    assign fetch_stall = hazard_s & ~flush;

    assign ctrl_out_s    = issue_s ? ctrl_s : '0;
    assign id_valid      = issue_s;
    assign illegal_instr = valid_r & ~legal_s;
    assign id_pc         = pc_r;
    assign id_funct3     = instr_r[14:12];
    assign id_funct7b5   = instr_r[30];

    assign RegWrite = ctrl_out_s.reg_write;
    assign MemRead  = ctrl_out_s.mem_read;
    assign MemWrite = ctrl_out_s.mem_write;
    assign MemtoReg = ctrl_out_s.mem_to_reg;
    assign ALUSrc   = ctrl_out_s.alu_src;
    assign Branch   = ctrl_out_s.branch;
    assign Jump     = ctrl_out_s.jump;
    assign ALUOp    = ctrl_out_s.alu_op;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr_r),
        .imm   (id_imm)
    );

    // IF/ID register: flush loads a bubble, stall holds, otherwise capture fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            instr_r <= NOP_INSTR;
        end else if (flush) begin
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
        end else if (fetch_stall) begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            instr_r <= instr_r;
        end else begin
            valid_r <= if_valid;
            pc_r    <= if_pc;
            instr_r <= if_instr;
        end
    end

    // EX tracking: record what actually issued (bubbles and flushes issue nothing).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rd_r      <= 5'd0;
            ex_memread_r <= 1'b0;
        end else begin
            ex_rd_r      <= issue_s ? rd : 5'd0;
            ex_memread_r <= issue_s & ctrl_s.mem_read;
        end
    end

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters for stalls and killed valid instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (hazard_s && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush && valid_r && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;
`endif

endmodule

// File: doc/if_id_decode_stage.md
Name: if_id_decode_stage

Overview:
- Front half of the decode stage in the RV64 pipeline. Sits between the fetch unit and the 32x64 register file.
- Holds the IF/ID pipeline register and decodes the held instruction into register addresses, a sign-extended immediate and control signals.
- Drives rs1/rs2/rd straight into the register file.
- Detects load-use hazards, stalls fetch and inserts bubbles. Honours branch flushes from EX.

Parameters:
- XLEN, 64, datapath/immediate/PC width
- ILEN, 32, instruction width
- NOP_INSTR, 32'h0000_0013, value loaded into the IF/ID instruction field on reset and flush (addi x0,x0,0)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- if_valid  in  1  fetch presents a valid instruction
- if_pc  in  XLEN  PC of the fetched instruction
- if_instr  in  ILEN  fetched instruction word
- flush  in  1  branch/jump taken in EX; kill the instruction in ID
- fetch_stall  out  1  fetch must hold its PC and instruction this cycle
- rs1, rs2, rd  out  5 each  register addresses to the register file and ID/EX
- id_valid  out  1  decoded outputs are a real instruction, not a bubble
- id_pc  out  XLEN  PC of the instruction in ID
- id_imm  out  XLEN  sign-extended immediate
- id_funct3  out  3  funct3 field
- id_funct7b5  out  1  instr[30]
- RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Jump  out  1 each  control signals
- ALUOp  out  2  00 add, 01 branch compare, 10 R/I-type funct decode
- illegal_instr  out  1  valid instruction with unsupported opcode

Behaviour:
- IF/ID register (valid, pc, instr) updates on posedge clk:
  - flush=1: valid<=0, instr<=NOP_INSTR.
  - Else fetch_stall=1: hold all fields.
  - Else: valid<=if_valid, pc<=if_pc, instr<=if_instr.
- Reset asserted (reset=0), asynchronously: valid=0, pc=0, instr=NOP_INSTR, EX-tracking regs=0. Consequently id_valid=0, fetch_stall=0, all control outputs 0, rs1/rs2/rd=0, id_imm=0.
- Decode is combinational from the IF/ID register. rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], always driven, including during bubbles.
- Supported opcodes and control:
  - R 0110011: RegWrite, ALUOp=10.
  - I-ALU 0010011: RegWrite, ALUSrc, ALUOp=10.
  - Load 0000011: RegWrite, MemRead, MemtoReg, ALUSrc.
  - Store 0100011: MemWrite, ALUSrc.
  - Branch 1100011: Branch, ALUOp=01.
  - LUI 0110111: RegWrite, ALUSrc.
  - JAL 1101111: RegWrite, Jump.
  - JALR 1100111: RegWrite, Jump, ALUSrc.
- Immediates (I/S/B/U/J) are sign-extended from the instruction MSB to XLEN. B and J have bit0=0. U is instr[31:12]<<12, sign-extended.
- Any other opcode with valid=1: illegal_instr=1 and the instruction is treated as a bubble.
- EX tracking: ex_rd_q and ex_memread_q register, every clock, the rd and MemRead actually issued this cycle. A bubble issues rd=0, MemRead=0. Flush also clears them.
- Load-use hazard: hazard = valid & ex_memread_q & (ex_rd_q!=0) & ((uses_rs1 & rs1==ex_rd_q) | (uses_rs2 & rs2==ex_rd_q)).
  - uses_rs1: all supported types except LUI and JAL.
  - uses_rs2: R, store, branch.
- On hazard: fetch_stall=1, id_valid=0, all control outputs forced to 0. IF/ID holds. Next cycle ex_memread_q=0, so a stall lasts exactly 1 cycle.
- Flush has priority over hazard: flush=1 forces id_valid=0, controls 0 and fetch_stall=0 in the same cycle.
- id_valid = valid & ~hazard & ~flush & ~illegal.
- Reset mid-stall: stall is dropped immediately and no bubble state is retained.

Optional Feature:
- IFID_PERF_CNT_EN defined: adds outputs stall_count and flush_count, 32 bits each.
  - stall_count increments on each cycle with hazard=1 and flush=0.
  - flush_count increments on each cycle with flush=1 and valid=1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR)
  - ALUOp encodings
  - NOP_INSTR
- One sub-module, imm_gen: combinational instr to XLEN immediate. The stage instantiates it once.

Test Plan:
- Reset release, then feed `add x3,x1,x2` (0x002081B3) at pc=0x100 → next cycle rs1=1, rs2=2, rd=3, RegWrite=1, ALUOp=10, id_valid=1, id_pc=0x100.
- `ld x5,8(x1)` then `add x6,x5,x7` → during add: fetch_stall=1 for exactly 1 cycle, id_valid=0, all controls 0. Next cycle the add issues with id_valid=1.
- `ld x0,0(x1)` then `add x6,x0,x7` → no stall.
- `lw` then `lui` using the same rd → no stall.
- `beq` imm=-4 (0xFE000EE3) → id_imm=64'hFFFF_FFFF_FFFF_FFFC, Branch=1, ALUOp=01.
- `jal` imm=+2048 → id_imm=0x800, Jump=1.
- Hazard cycle with flush=1 → id_valid=0, fetch_stall=0. Next cycle IF/ID valid=0. With IFID_PERF_CNT_EN: flush_count=1, stall_count=0.
- Opcode 0x7F with if_valid=1 → illegal_instr=1, id_valid=0.
- reset pulsed low mid-stall → fetch_stall=0 asynchronously and all outputs at reset values.
